pc_flow_checker: RTL and testbench

Passive PC-sequence checker that sits beside the single-cycle core and consumes the program-counter stream the core produces. It samples each retired PC together with the PCSrc value that governs the next fetch. It verifies that every PC equals the value the previous PCSrc selected (sequential +4 or taken +BRANCH_OFFSET) and keeps retired-instruction and taken-branch counts. On the first violation it freezes, captures diagnostic state, and holds a sticky error until cleared.

---
 rtl/pc_flow_checker.sv | 136 +++++++++++++
 tb/tb_pc_flow_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_flow_checker.sv
// Passive checker for the retired-PC stream of the single-cycle core.
// Verifies each PC against the previous PCSrc selection, counts accepted PCs, and freezes on the first violation.
module pc_flow_checker #(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              BRANCH_OFFSET = 16,
    parameter logic [DATA_WIDTH-1:0]    RESET_PC      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  pcsrc_in,
    input  logic                  clear_in,
    output logic [DATA_WIDTH-1:0] instr_count,
    output logic [DATA_WIDTH-1:0] branch_count,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] err_pc,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_e;

    localparam logic [DATA_WIDTH-1:0] SEQ_STEP = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] BR_STEP  = DATA_WIDTH'(BRANCH_OFFSET);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                  last_pcsrc_q, last_pcsrc_d;
    logic [DATA_WIDTH-1:0] instr_count_q, instr_count_d;
    logic [DATA_WIDTH-1:0] branch_count_q, branch_count_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] err_pc_q, err_pc_d;
    logic [DATA_WIDTH-1:0] err_expected_q, err_expected_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH-1:0] expected_c;
    logic                  mismatch_c;

    // Expected PC: RESET_PC before the first accepted sample, otherwise last PC plus the selected step
    always_comb begin
        if (state_q == IDLE) begin
            expected_c = RESET_PC;
        end else begin
            expected_c = last_pc_q + (last_pcsrc_q ? BR_STEP : SEQ_STEP);
        end
        mismatch_c = (pc_in != expected_c) || (pc_in[1:0] != 2'b00);
    end

    // Next-state and datapath update
    always_comb begin
        state_d        = state_q;
        last_pc_d      = last_pc_q;
        last_pcsrc_d   = last_pcsrc_q;
        instr_count_d  = instr_count_q;
        branch_count_d = branch_count_q;
        error_d        = error_q;
        err_pc_d       = err_pc_q;
        err_expected_d = err_expected_q;

        case (state_q)
            IDLE, RUN: begin
                if (valid_in) begin
                    if (mismatch_c) begin
                        state_d        = ERROR;
                        error_d        = 1'b1;
                        err_pc_d       = pc_in;
                        err_expected_d = expected_c;
                    end else begin
                        state_d      = RUN;
                        last_pc_d    = pc_in;
                        last_pcsrc_d = pcsrc_in;
                        if (instr_count_q != ALL_ONES) begin
                            instr_count_d = instr_count_q + DATA_WIDTH'(1);
                        end
                        if (pcsrc_in && (branch_count_q != ALL_ONES)) begin
                            branch_count_d = branch_count_q + DATA_WIDTH'(1);
                        end
                    end
                end
            end
            default: ;
        endcase

        // Soft clear wins over any same-cycle sample
        if (clear_in) begin
            state_d        = IDLE;
            last_pc_d      = '0;
            last_pcsrc_d   = 1'b0;
            instr_count_d  = '0;
            branch_count_d = '0;
            error_d        = 1'b0;
            err_pc_d       = '0;
            err_expected_d = '0;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_pc_q      <= '0;
            last_pcsrc_q   <= 1'b0;
            instr_count_q  <= '0;
            branch_count_q <= '0;
            error_q        <= 1'b0;
            err_pc_q       <= '0;
            err_expected_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_pc_q      <= last_pc_d;
            last_pcsrc_q   <= last_pcsrc_d;
            instr_count_q  <= instr_count_d;
            branch_count_q <= branch_count_d;
            error_q        <= error_d;
            err_pc_q       <= err_pc_d;
            err_expected_q <= err_expected_d;
            busy_q         <= busy_d;
        end
    end

    assign instr_count  = instr_count_q;
    assign branch_count = branch_count_q;
    assign error        = error_q;
    assign err_pc       = err_pc_q;
    assign err_expected = err_expected_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pc_flow_checker.sv
// Directed bench for pc_flow_checker: default, wrapped-RESET_PC and narrow saturating instances share one stimulus bus.
module tb_pc_flow_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pcsrc_in = 1'b0;
    logic        clear_in = 1'b0;

    logic [31:0] instr_count, branch_count, err_pc, err_expected;
    logic        error, busy;
    logic [31:0] w_instr_count, w_branch_count, w_err_pc, w_err_expected;
    logic        w_error, w_busy;
    logic [3:0]  n_instr_count, n_branch_count, n_err_pc, n_err_expected;
    logic        n_error, n_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_flow_checker dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .pcsrc_in(pcsrc_in),
        .clear_in(clear_in), .instr_count(instr_count), .branch_count(branch_count),
        .error(error), .err_pc(err_pc), .err_expected(err_expected), .busy(busy)
    );

    pc_flow_checker #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .pcsrc_in(pcsrc_in),
        .clear_in(clear_in), .instr_count(w_instr_count), .branch_count(w_branch_count),
        .error(w_error), .err_pc(w_err_pc), .err_expected(w_err_expected), .busy(w_busy)
    );

    pc_flow_checker #(.DATA_WIDTH(4), .RESET_PC(4'h0)) dut_narrow (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in[3:0]), .pcsrc_in(pcsrc_in),
        .clear_in(clear_in), .instr_count(n_instr_count), .branch_count(n_branch_count),
        .error(n_error), .err_pc(n_err_pc), .err_expected(n_err_expected), .busy(n_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; valid_in = 1'b0; clear_in = 1'b0; pcsrc_in = 1'b0; pc_in = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic src);
        valid_in = 1'b1; pc_in = pc; pcsrc_in = src;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic bubbles(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (instr_count !== 32'd0) begin n_bad++; $display("FAIL reset_instr got %0d want 0", instr_count); end
        n_cmp++; if (branch_count !== 32'd0) begin n_bad++; $display("FAIL reset_branch got %0d want 0", branch_count); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (err_pc !== 32'd0 || err_expected !== 32'd0) begin
            n_bad++; $display("FAIL reset_capture got %h/%h want 0/0", err_pc, err_expected); end
    endtask

    task automatic test_sequential();
        do_reset();
        send(32'd0, 1'b0); send(32'd4, 1'b0); send(32'd8, 1'b0); send(32'd12, 1'b0);
        n_cmp++; if (instr_count !== 32'd4) begin n_bad++; $display("FAIL seq_instr got %0d want 4", instr_count); end
        n_cmp++; if (branch_count !== 32'd0) begin n_bad++; $display("FAIL seq_branch got %0d want 0", branch_count); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL seq_error got %b want 0", error); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL seq_busy got %b want 1", busy); end
    endtask

    task automatic test_branch();
        do_reset();
        send(32'd0, 1'b1); send(32'd16, 1'b0); send(32'd20, 1'b0);
        n_cmp++; if (instr_count !== 32'd3) begin n_bad++; $display("FAIL br_instr got %0d want 3", instr_count); end
        n_cmp++; if (branch_count !== 32'd1) begin n_bad++; $display("FAIL br_branch got %0d want 1", branch_count); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL br_error got %b want 0", error); end
    endtask

    task automatic test_mismatch();
        do_reset();
        send(32'd0, 1'b0); send(32'd4, 1'b1);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL mm_pre_error got %b want 0", error); end
        send(32'd8, 1'b0);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL mm_error got %b want 1", error); end
        n_cmp++; if (err_pc !== 32'd8) begin n_bad++; $display("FAIL mm_err_pc got %0d want 8", err_pc); end
        n_cmp++; if (err_expected !== 32'd20) begin n_bad++; $display("FAIL mm_err_exp got %0d want 20", err_expected); end
        n_cmp++; if (instr_count !== 32'd2) begin n_bad++; $display("FAIL mm_instr got %0d want 2", instr_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mm_busy got %b want 0", busy); end
        // Frozen: a correct-looking and a branch sample are both ignored
        send(32'd20, 1'b1); send(32'd0, 1'b1);
        n_cmp++; if (error !== 1'b1 || err_pc !== 32'd8 || err_expected !== 32'd20
                     || instr_count !== 32'd2 || branch_count !== 32'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mm_frozen got err=%b pc=%0d exp=%0d ic=%0d bc=%0d busy=%b want 1/8/20/2/1/0",
                              error, err_pc, err_expected, instr_count, branch_count, busy); end
    endtask

    task automatic test_bad_start_align();
        do_reset();
        send(32'h40, 1'b0);
        n_cmp++; if (error !== 1'b1 || err_pc !== 32'h40 || err_expected !== 32'd0) begin
            n_bad++; $display("FAIL start_err got %b/%h/%h want 1/40/0", error, err_pc, err_expected); end
        n_cmp++; if (instr_count !== 32'd0) begin n_bad++; $display("FAIL start_instr got %0d want 0", instr_count); end
        clear_in = 1'b1; tick(); clear_in = 1'b0;
        send(32'd0, 1'b0); send(32'd6, 1'b0);
        n_cmp++; if (error !== 1'b1 || err_pc !== 32'd6 || err_expected !== 32'd4) begin
            n_bad++; $display("FAIL align_err got %b/%0d/%0d want 1/6/4", error, err_pc, err_expected); end
        n_cmp++; if (instr_count !== 32'd1) begin n_bad++; $display("FAIL align_instr got %0d want 1", instr_count); end
    endtask

    task automatic test_wrap_bubbles();
        do_reset();
        send(32'hFFFF_FFF8, 1'b0); bubbles(3);
        send(32'hFFFF_FFFC, 1'b0); bubbles(3);
        send(32'h0000_0000, 1'b0);
        n_cmp++; if (w_error !== 1'b0) begin n_bad++; $display("FAIL wrap_error got %b want 0 (pc %h)", w_error, w_err_pc); end
        n_cmp++; if (w_instr_count !== 32'd3) begin n_bad++; $display("FAIL wrap_instr got %0d want 3", w_instr_count); end
        n_cmp++; if (w_busy !== 1'b1) begin n_bad++; $display("FAIL wrap_busy got %b want 1", w_busy); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        send(32'd8, 1'b0);
        clear_in = 1'b1; valid_in = 1'b1; pc_in = 32'd0; pcsrc_in = 1'b1;
        tick();
        clear_in = 1'b0; valid_in = 1'b0;
        n_cmp++; if (error !== 1'b0 || instr_count !== 32'd0 || branch_count !== 32'd0 || busy !== 1'b0
                     || err_pc !== 32'd0 || err_expected !== 32'd0) begin
            n_bad++; $display("FAIL clr_state got err=%b ic=%0d bc=%0d busy=%b epc=%0d eexp=%0d want all 0",
                              error, instr_count, branch_count, busy, err_pc, err_expected); end
        // Back in IDLE: next PC must be RESET_PC again
        send(32'd0, 1'b0);
        n_cmp++; if (error !== 1'b0 || instr_count !== 32'd1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL clr_restart got err=%b ic=%0d busy=%b want 0/1/1", error, instr_count, busy); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        send(32'd0, 1'b0); send(32'd4, 1'b0);
        do_reset();
        send(32'd8, 1'b0);
        n_cmp++; if (error !== 1'b1 || err_expected !== 32'd0) begin
            n_bad++; $display("FAIL midrst got %b/%0d want 1/0", error, err_expected); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) send(32'(i * 4), 1'b0);
        n_cmp++; if (n_error !== 1'b0) begin n_bad++; $display("FAIL sat_error got %b want 0", n_error); end
        n_cmp++; if (n_instr_count !== 4'hF) begin n_bad++; $display("FAIL sat_instr got %0d want 15", n_instr_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_mismatch();
        test_bad_start_align();
        test_wrap_bubbles();
        test_clear_priority();
        test_reset_midrun();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
